// File: rtl/miriscv_data_mem.sv
// Data-memory responder for the miriscv LSU: byte-masked word writes and registered word reads.
// Each access completes with a one-cycle ready pulse after WAIT_STATES extra cycles.
module miriscv_data_mem #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        commit;
  logic        cur_we;
  logic [3:0]  cur_be;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] idx;

  assign accept = data_req_i && ((state == S_IDLE) || (state == S_DONE));

  // With zero wait states the access commits on the accept edge, so it must use
  // the live inputs; otherwise it commits from WAIT using the latched copy.
  always_comb begin
    cur_we    = data_we_i;
    cur_be    = data_be_i;
    cur_addr  = data_addr_i;
    cur_wdata = data_wdata_i;
    if (state == S_WAIT) begin
      cur_we    = we_q;
      cur_be    = be_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign commit = arstn_i &&
                  (((state == S_WAIT) && (cnt == 4'd0)) || (accept && (WAIT_STATES == 0)));

  // Unsigned subtract: addresses below BASE_ADDR wrap high and fall out of range.
  assign offset   = cur_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[AW+1:2];

  assign data_ready_o = (state == S_DONE);

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= data_we_i;
        be_q    <= data_be_i;
        addr_q  <= data_addr_i;
        wdata_q <= data_wdata_i;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (data_req_i) begin
            if (WAIT_STATES > 0) begin
              state <= S_WAIT;
              cnt   <= WS_LOAD;
            end else begin
              state <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (commit && cur_we && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (cur_be[k]) mem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      data_rdata_o <= 32'd0;
    end else if (commit && !cur_we) begin
      data_rdata_o <= in_range ? mem[idx] : 32'd0;
    end
  end

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Scoreboard bench for miriscv_data_mem: two instances (0 and 1 wait states, different bases)
// driven with directed and random accesses against an array-based memory model.
module tb_miriscv_data_mem;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE0 = 32'h400;
  localparam logic [31:0] BASE1 = 32'h0;

  logic clk = 1'b0;
  logic arstn = 1'b0;
  always #5 clk = ~clk;

  logic        req [2];
  logic        we  [2];
  logic [3:0]  be  [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata0, rdata1;
  logic        rdy0, rdy1;

  miriscv_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .WAIT_STATES(0), .INIT_FILE("")) u_dut0 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req[0]), .data_we_i(we[0]), .data_be_i(be[0]),
    .data_addr_i(addr[0]), .data_wdata_i(wdata[0]), .data_rdata_o(rdata0), .data_ready_o(rdy0));

  miriscv_data_mem #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(1), .INIT_FILE("")) u_dut1 (
    .clk_i(clk), .arstn_i(arstn), .data_req_i(req[1]), .data_we_i(we[1]), .data_be_i(be[1]),
    .data_addr_i(addr[1]), .data_wdata_i(wdata[1]), .data_rdata_o(rdata1), .data_ready_o(rdy1));

  typedef struct {
    int          d;
    logic [31:0] rd;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        sbq [$];
  logic [31:0] mdl [2][DEPTH];
  logic [31:0] last_rd [2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endfunction

  function automatic logic [31:0] base_of(int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic logic rdy_of(int d);
    return (d == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic [31:0] rdata_of(int d);
    return (d == 0) ? rdata0 : rdata1;
  endfunction

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  function automatic void mon(int d);
    exp_t e;
    if (sbq.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_ready dut%0d: got ready=1 expected 0 (nothing outstanding)", d);
    end else begin
      e = sbq.pop_front();
      chk({e.nm, "_dut"}, 32'(d), 32'(e.d));
      chk({e.nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
      chk({e.nm, "_rdata"}, rdata_of(d), e.rd);
    end
  endfunction

  always @(negedge clk) begin
    if (rdy0) mon(0);
    if (rdy1) mon(1);
  end

  task automatic wait_ready(int d, string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (rdy_of(d)) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: got ready=0 expected 1 within 40 cycles", nm);
      sbq.delete();
    end
  endtask

  // Called at a falling edge; the access is accepted at the next rising edge and
  // ready is seen one cycle later per wait state beyond that.
  task automatic issue(int d, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] wd, string nm);
    logic [31:0] off;
    bit          inr;
    int          idx;
    exp_t        e;
    off = a - base_of(d);
    inr = (off < 32'(DEPTH * 4));
    idx = inr ? int'(off >> 2) : 0;
    if (w) begin
      if (inr) for (int k = 0; k < 4; k++) if (b[k]) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
      e.rd = last_rd[d];
    end else begin
      e.rd = inr ? mdl[d][idx] : 32'h0;
      last_rd[d] = e.rd;
    end
    e.d   = d;
    e.cyc = cyc + 1 + d;
    e.nm  = nm;
    sbq.push_back(e);
    req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
    wait_ready(d, nm);
  endtask

  task automatic idle(int d, int n);
    req[d] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0; last_rd[d] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_rdy0", 32'(rdy0), 32'd0);
    chk("reset_rdy1", 32'(rdy1), 32'd0);
    chk("reset_rdata0", rdata0, 32'd0);
    chk("reset_rdata1", rdata1, 32'd0);
    arstn = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < DEPTH; i++) issue(d, 1'b1, 4'hF, base_of(d) + 32'(i * 4), $urandom, "preload");
      idle(d, 1);
    end

    // Reset in the middle of a write's wait state: the write must never land.
    req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h10; wdata[1] = 32'hDEADBEEF;
    @(negedge clk);
    #2;
    arstn = 1'b0;
    req[1] = 1'b0;
    chk("abort_rdy", 32'(rdy1), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_rdy_hold", 32'(rdy1), 32'd0);
      chk("abort_rdata", rdata1, 32'd0);
    end
    arstn = 1'b1;
    last_rd[0] = 0;
    last_rd[1] = 0;
    @(negedge clk);
    issue(1, 1'b0, 4'h0, 32'h10, 32'h0, "t1_rd"); idle(1, 1);

    issue(1, 1'b1, 4'hF, 32'h20, 32'h11223344, "t2_wr"); idle(1, 1);
    issue(1, 1'b0, 4'h0, 32'h20, 32'h0, "t2_rd");
    chk("t2_const", rdata1, 32'h11223344);
    idle(1, 1);

    issue(1, 1'b1, 4'b0100, 32'h22, 32'hAAAAAAAA, "t3_wr"); idle(1, 1);
    issue(1, 1'b0, 4'h0, 32'h20, 32'h0, "t3_rd");
    chk("t3_const", rdata1, 32'h11AA3344);
    idle(1, 1);

    issue(1, 1'b1, 4'hF, BASE1 + 32'(DEPTH * 4), 32'h1, "t5_wr"); idle(1, 1);
    issue(1, 1'b0, 4'h0, BASE1 + 32'(DEPTH * 4), 32'h0, "t5_rd");
    chk("t5_const", rdata1, 32'h0);
    idle(1, 1);
    issue(1, 1'b0, 4'h0, BASE1, 32'h0, "t5_word0"); idle(1, 1);

    issue(1, 1'b1, 4'h0, 32'h30, 32'hFFFFFFFF, "t6_wr"); idle(1, 1);
    issue(1, 1'b0, 4'h0, 32'h30, 32'h0, "t6_rd"); idle(1, 1);

    // Zero wait states, request held: three ready pulses on consecutive cycles.
    issue(0, 1'b0, 4'h0, BASE0 + 32'h10, 32'h0, "t4_rd0");
    issue(0, 1'b0, 4'h0, BASE0 + 32'h14, 32'h0, "t4_rd1");
    issue(0, 1'b0, 4'h0, BASE0 + 32'h18, 32'h0, "t4_rd2");
    idle(0, 1);
    issue(0, 1'b0, 4'h0, BASE0 - 32'h4, 32'h0, "below_base"); idle(0, 1);

    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 200; n++) begin
        int r;
        int gap;
        r = $urandom_range(0, 9);
        if (r == 0)      a = base_of(d) + 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
        else if (r == 1) a = base_of(d) - 32'($urandom_range(1, 8));
        else if (r < 6)  a = base_of(d) + 32'($urandom_range(0, 15));
        else             a = base_of(d) + 32'($urandom_range(0, DEPTH * 4 - 1));
        issue(d, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, "rand");
        gap = $urandom_range(0, 2);
        if (gap > 0) idle(d, gap);
      end
      idle(d, 2);
    end

    repeat (5) @(negedge clk);
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
